// File: rtl/bcrypt_core_scheduler.sv
// rtl/bcrypt_core_scheduler.sv - masked start/done sequencer for the bcrypt_loop core array
// Optional watchdog timeout is compiled in when BCRYPT_WDOG_EN is defined.
module bcrypt_core_scheduler #(
  parameter int NUM_CORES = 28,
  parameter int CNT_W     = 32
) (
  input  logic                 Bus2IP_Clk,
  input  logic                 Bus2IP_Reset,
  input  logic                 ctrl_go,
  input  logic                 ctrl_abort,
  input  logic [NUM_CORES-1:0] mask_in,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [CNT_W-1:0]     wdog_limit,
  output logic [NUM_CORES-1:0] start,
  output logic [NUM_CORES-1:0] done_map,
  output logic                 busy,
  output logic [31:0]          status_word,
  output logic [CNT_W-1:0]     run_cycles,
  output logic                 wdog_timeout
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARM      = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_COMPLETE = 3'd4;
  localparam logic [2:0] S_TIMEOUT  = 3'd5;

  localparam logic [31:0] STATUS_COMPLETE = 32'h0000_00FF;
  localparam logic [31:0] STATUS_TIMEOUT  = 32'h0000_00EE;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [NUM_CORES-1:0] mask;
  logic [NUM_CORES-1:0] mask_nxt;
  logic [NUM_CORES-1:0] done_map_nxt;
  logic [NUM_CORES-1:0] start_nxt;
  logic [CNT_W-1:0]     run_cycles_nxt;
  logic [CNT_W-1:0]     run_cycles_inc;
  logic [31:0]          status_nxt;
  logic                 busy_nxt;
  logic                 wdog_timeout_nxt;
  logic                 wdog_trip;
  logic                 all_done;

  assign all_done       = ((done_map & mask) == mask);
  assign run_cycles_inc = (&run_cycles) ? run_cycles : run_cycles + 1'b1;

`ifdef BCRYPT_WDOG_EN
  assign wdog_trip = (wdog_limit != '0) && (run_cycles >= wdog_limit);
`else
  logic unused_wdog_limit;
  assign unused_wdog_limit = ^wdog_limit;
  assign wdog_trip         = 1'b0;
`endif

  always_comb begin
    state_nxt        = state;
    mask_nxt         = mask;
    done_map_nxt     = done_map;
    run_cycles_nxt   = run_cycles;
    start_nxt        = '0;
    wdog_timeout_nxt = wdog_timeout;

    // Abort beats everything, including a simultaneous go; readback state is kept.
    if (ctrl_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_COMPLETE, S_TIMEOUT: begin
          if (ctrl_go) begin
            mask_nxt         = mask_in;
            done_map_nxt     = '0;
            run_cycles_nxt   = '0;
            wdog_timeout_nxt = 1'b0;
            state_nxt        = (mask_in == '0) ? S_COMPLETE : S_ARM;
          end
        end
        S_ARM: begin
          // Port A mux flips one cycle after go so pending PS writes land first.
          state_nxt = S_RUN;
          start_nxt = mask;
        end
        S_RUN: begin
          done_map_nxt   = done_map | (core_done & mask);
          run_cycles_nxt = run_cycles_inc;
          if (all_done) begin
            state_nxt = S_DRAIN;
          end else if (wdog_trip) begin
            state_nxt        = S_TIMEOUT;
            wdog_timeout_nxt = 1'b1;
          end else begin
            start_nxt = mask & ~done_map;
          end
        end
        S_DRAIN: begin
          state_nxt = S_COMPLETE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end

    case (state_nxt)
      S_COMPLETE: status_nxt = STATUS_COMPLETE;
      S_TIMEOUT:  status_nxt = STATUS_TIMEOUT;
      default:    status_nxt = '0;
    endcase
    busy_nxt = (state_nxt == S_ARM) || (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
  end

  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      state        <= S_IDLE;
      mask         <= '0;
      done_map     <= '0;
      start        <= '0;
      run_cycles   <= '0;
      busy         <= 1'b0;
      status_word  <= '0;
      wdog_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      mask         <= mask_nxt;
      done_map     <= done_map_nxt;
      start        <= start_nxt;
      run_cycles   <= run_cycles_nxt;
      busy         <= busy_nxt;
      status_word  <= status_nxt;
      wdog_timeout <= wdog_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_bcrypt_core_scheduler.sv
// tb/tb_bcrypt_core_scheduler.sv - directed and randomized checks of bcrypt_core_scheduler
// Expected values come from per-core done times (start high through done+1, completion at last+3).
module tb_bcrypt_core_scheduler;

  localparam int NC = 28;
  localparam int CW = 32;
  localparam logic [NC-1:0] ALL = {NC{1'b1}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ctrl_go = 1'b0;
  logic          ctrl_abort = 1'b0;
  logic [NC-1:0] mask_in = '0;
  logic [NC-1:0] core_done = '0;
  logic [CW-1:0] wdog_limit = '0;
  logic [NC-1:0] start;
  logic [NC-1:0] done_map;
  logic          busy;
  logic [31:0]   status_word;
  logic [CW-1:0] run_cycles;
  logic          wdog_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  bcrypt_core_scheduler #(.NUM_CORES(NC), .CNT_W(CW)) dut (
    .Bus2IP_Clk   (clk),
    .Bus2IP_Reset (rst),
    .ctrl_go      (ctrl_go),
    .ctrl_abort   (ctrl_abort),
    .mask_in      (mask_in),
    .core_done    (core_done),
    .wdog_limit   (wdog_limit),
    .start        (start),
    .done_map     (done_map),
    .busy         (busy),
    .status_word  (status_word),
    .run_cycles   (run_cycles),
    .wdog_timeout (wdog_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [NC-1:0] e_start, input logic [NC-1:0] e_dm,
                            input logic e_busy, input logic [31:0] e_status, input logic [CW-1:0] e_rc);
    check({tag, ".start"}, start, e_start);
    check({tag, ".done_map"}, done_map, e_dm);
    check({tag, ".busy"}, busy, e_busy);
    check({tag, ".status"}, status_word, e_status);
    check({tag, ".run_cycles"}, run_cycles, e_rc);
  endtask

  // One full pass; dt[i] is the RUN cycle (1-based) in which core i pulses done.
  task automatic run_pass(input string tag, input logic [NC-1:0] m, input int dt [NC], input bit noise);
    int last;
    logic [NC-1:0] e_start;
    logic [NC-1:0] e_dm;
    logic [NC-1:0] pulse;
    last = 0;
    for (int i = 0; i < NC; i++)
      if (m[i] && dt[i] > last) last = dt[i];
    mask_in = m;
    ctrl_go = 1'b1;
    step();
    ctrl_go = 1'b0;
    check_outs({tag, ".arm"}, '0, '0, 1'b1, 32'h0, '0);
    step();
    for (int k = 1; k <= last + 1; k++) begin
      e_start = '0;
      e_dm    = '0;
      pulse   = '0;
      for (int i = 0; i < NC; i++) begin
        if (m[i] && k <= dt[i] + 1) e_start[i] = 1'b1;
        if (m[i] && dt[i] < k)      e_dm[i]    = 1'b1;
        if (m[i] && dt[i] == k)     pulse[i]   = 1'b1;
      end
      check_outs($sformatf("%s.run%0d", tag, k), e_start, e_dm, 1'b1, 32'h0, CW'(k - 1));
      core_done = pulse;
      if (noise) begin
        core_done = pulse | (NC'($urandom) & ~m);
        ctrl_go   = ($urandom_range(0, 5) == 0);
        mask_in   = NC'($urandom);
      end
      step();
      core_done = '0;
      ctrl_go   = 1'b0;
    end
    check_outs({tag, ".drain"}, '0, m, 1'b1, 32'h0, CW'(last + 1));
    step();
    check_outs({tag, ".complete"}, '0, m, 1'b0, 32'hFF, CW'(last + 1));
  endtask

  initial begin
    int dt [NC];
    logic [NC-1:0] m;

    // Reset state
    #12;
    check_outs("reset", '0, '0, 1'b0, 32'h0, '0);
    check("reset.wdog", wdog_timeout, 1'b0);
    rst = 1'b0;
    step();

    // Two cores, done at RUN cycles 10 and 20
    for (int i = 0; i < NC; i++) dt[i] = 0;
    dt[0] = 10;
    dt[1] = 20;
    run_pass("t1", 28'h0000003, dt, 1'b0);

    // go with a simultaneous done pulse in COMPLETE: go wins, done_map cleared
    mask_in   = 28'h0000003;
    ctrl_go   = 1'b1;
    core_done = ALL;
    step();
    ctrl_go   = 1'b0;
    core_done = '0;
    check_outs("go_in_complete", '0, '0, 1'b1, 32'h0, '0);
    ctrl_abort = 1'b1;
    step();
    ctrl_abort = 1'b0;
    check_outs("abort_from_arm", '0, '0, 1'b0, 32'h0, '0);

    // Empty mask completes immediately, start never rises
    mask_in = '0;
    ctrl_go = 1'b1;
    step();
    ctrl_go = 1'b0;
    check_outs("t2.next", '0, '0, 1'b0, 32'hFF, '0);
    step();
    check_outs("t2.hold", '0, '0, 1'b0, 32'hFF, '0);

    // All cores, random order, two in the same cycle, noise go/unmasked pulses
    for (int i = 0; i < NC; i++) dt[i] = $urandom_range(1, 40);
    dt[17] = dt[5];
    run_pass("t3", ALL, dt, 1'b1);

    // Random masks and done schedules
    for (int p = 0; p < 6; p++) begin
      m = NC'($urandom);
      if (m == '0) m = 28'h0000001;
      for (int i = 0; i < NC; i++) dt[i] = $urandom_range(1, 30);
      run_pass($sformatf("rnd%0d", p), m, dt, 1'b1);
    end

    // Abort mid-RUN with done_map=5
    mask_in = 28'h000000F;
    ctrl_go = 1'b1;
    step();
    ctrl_go = 1'b0;
    step();
    core_done = 28'h0000005;
    step();
    core_done = '0;
    step();
    check_outs("t4.pre", 28'h000000A, 28'h0000005, 1'b1, 32'h0, 32'd2);
    ctrl_abort = 1'b1;
    step();
    ctrl_abort = 1'b0;
    check_outs("t4.abort", '0, 28'h0000005, 1'b0, 32'h0, 32'd2);
    step();
    check_outs("t4.idle", '0, 28'h0000005, 1'b0, 32'h0, 32'd2);
    ctrl_abort = 1'b1;
    ctrl_go    = 1'b1;
    mask_in    = 28'h000000F;
    step();
    ctrl_abort = 1'b0;
    ctrl_go    = 1'b0;
    check_outs("t4.abort_go", '0, 28'h0000005, 1'b0, 32'h0, 32'd2);
    step();
    check_outs("t4.no_arm", '0, 28'h0000005, 1'b0, 32'h0, 32'd2);

    // Watchdog with limit 100 and no done pulses
    wdog_limit = 32'd100;
    mask_in    = 28'h0000001;
    ctrl_go    = 1'b1;
    step();
    ctrl_go = 1'b0;
    step();
    for (int k = 0; k < 101; k++) step();
`ifdef BCRYPT_WDOG_EN
    check_outs("t6.timeout", '0, '0, 1'b0, 32'hEE, 32'd101);
    check("t6.wdog", wdog_timeout, 1'b1);
    ctrl_abort = 1'b1;
    step();
    ctrl_abort = 1'b0;
    wdog_limit = '0;
    ctrl_go    = 1'b1;
    step();
    ctrl_go = 1'b0;
    check("t6.go_clears_wdog", wdog_timeout, 1'b0);
    step();
    for (int k = 0; k < 150; k++) step();
    check_outs("t6.limit0", 28'h0000001, '0, 1'b1, 32'h0, 32'd150);
    check("t6.limit0.wdog", wdog_timeout, 1'b0);
`else
    check_outs("t6.no_wdog", 28'h0000001, '0, 1'b1, 32'h0, 32'd101);
    check("t6.wdog", wdog_timeout, 1'b0);
`endif
    ctrl_abort = 1'b1;
    step();
    ctrl_abort = 1'b0;
    wdog_limit = '0;

    // Asynchronous reset mid-RUN
    mask_in = 28'h0000003;
    ctrl_go = 1'b1;
    step();
    ctrl_go = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("t5.pre.busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_outs("t5.async", '0, '0, 1'b0, 32'h0, '0);
    check("t5.async.wdog", wdog_timeout, 1'b0);
    step();
    rst = 1'b0;
    step();
    check_outs("t5.after", '0, '0, 1'b0, 32'h0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
